// File: rtl/frame_stream_source_if.sv
// Write-port and sof/data/valid stream bundle of the frame source.
// The source takes the master side; layer benches and consumers take the slave side.
interface frame_stream_source_if #(
    parameter int data_width = 32,
    parameter int addr_w     = 5
);
    logic                  wr_en;
    logic [addr_w-1:0]     wr_addr;
    logic [data_width-1:0] wr_data;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  sof;
    logic                  output_valid;
    logic [data_width-1:0] d_out;

    modport master (
        input  wr_en, wr_addr, wr_data, start,
        output busy, done, sof, output_valid, d_out
    );

    modport slave (
        output wr_en, wr_addr, wr_data, start,
        input  busy, done, sof, output_valid, d_out
    );
endinterface

// File: rtl/frame_stream_source.sv
// Holds one input_x x input_y feature map and replays it in raster order
// as a sof/valid/data stream, with optional idle cycles between rows.
module frame_stream_source #(
    parameter int data_width = 32,
    parameter int input_x    = 5,
    parameter int input_y    = 5,
    parameter int row_gap    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    frame_stream_source_if.master bus
);
    localparam int DEPTH = input_x * input_y;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = (input_y > 1) ? $clog2(input_y) : 1;
    localparam int RW    = (input_x > 1) ? $clog2(input_x) : 1;

    localparam logic [CW-1:0] COL_LAST   = CW'(input_y - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(input_x - 1);
    localparam logic [7:0]    GAP_LOAD   = 8'(row_gap);
    localparam logic [AW-1:0] ROW_STRIDE = AW'(input_y);
    localparam logic [AW:0]   DEPTH_W    = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, STREAM, GAP, FLUSH} state_t;

    state_t                r_state, w_state_nxt;
    logic [RW-1:0]         r_row, w_row_nxt;
    logic [CW-1:0]         r_col, w_col_nxt;
    logic [7:0]            r_gap, w_gap_nxt;
    logic                  w_rd_p0;
    logic                  w_flush_exit;
    logic                  w_start_ok;
    logic                  w_wr_ok;
    logic [AW-1:0]         w_rd_addr;

    logic                  r_rd_p0, r_sof_p0;
    logic [AW-1:0]         r_addr_p0;
    logic                  r_vld_p1, r_sof_p1;
    logic [data_width-1:0] r_dout_p1;
    logic                  r_busy, r_done_p0, r_done_p1;

    logic [data_width-1:0] r_mem [DEPTH];

    // A start is only taken once the previous frame's done pulse has gone by.
    assign w_start_ok = bus.start && !r_busy && !r_done_p1;
    assign w_wr_ok    = bus.wr_en && !r_busy && ({1'b0, bus.wr_addr} < DEPTH_W);
    assign w_rd_addr  = AW'(r_row) * ROW_STRIDE + AW'(r_col);

    always_comb begin
        w_state_nxt  = r_state;
        w_row_nxt    = r_row;
        w_col_nxt    = r_col;
        w_gap_nxt    = r_gap;
        w_rd_p0      = 1'b0;
        w_flush_exit = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = STREAM;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                end
            end
            STREAM: begin
                w_rd_p0 = 1'b1;
                if (r_col == COL_LAST) begin
                    w_col_nxt = '0;
                    if (r_row == ROW_LAST) begin
                        w_state_nxt = FLUSH;
                    end else if (GAP_LOAD != 8'd0) begin
                        w_state_nxt = GAP;
                        w_gap_nxt   = GAP_LOAD;
                    end else begin
                        w_row_nxt = r_row + RW'(1);
                    end
                end else begin
                    w_col_nxt = r_col + CW'(1);
                end
            end
            GAP: begin
                if (r_gap == 8'd1) begin
                    w_state_nxt = STREAM;
                    w_row_nxt   = r_row + RW'(1);
                end else begin
                    w_gap_nxt = r_gap - 8'd1;
                end
            end
            FLUSH: begin
                w_state_nxt  = IDLE;
                w_flush_exit = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Stage p0: read issue registered; stage p1: RAM word and flags presented.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_row     <= '0;
            r_col     <= '0;
            r_gap     <= '0;
            r_rd_p0   <= 1'b0;
            r_sof_p0  <= 1'b0;
            r_vld_p1  <= 1'b0;
            r_sof_p1  <= 1'b0;
            r_dout_p1 <= '0;
            r_busy    <= 1'b0;
            r_done_p0 <= 1'b0;
            r_done_p1 <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_row     <= w_row_nxt;
            r_col     <= w_col_nxt;
            r_gap     <= w_gap_nxt;
            r_rd_p0   <= w_rd_p0;
            r_sof_p0  <= w_rd_p0 && (r_row == '0) && (r_col == '0);
            r_vld_p1  <= r_rd_p0;
            r_sof_p1  <= r_sof_p0;
            if (r_rd_p0) begin
                r_dout_p1 <= r_mem[r_addr_p0];
            end
            r_busy    <= (r_state != IDLE);
            r_done_p0 <= w_flush_exit;
            r_done_p1 <= r_done_p0;
        end
    end

    // Frame RAM and read address carry no reset so the map survives resets.
    always_ff @(posedge clk) begin
        r_addr_p0 <= w_rd_addr;
        if (rst && w_wr_ok) begin
            r_mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign bus.busy         = r_busy;
    assign bus.done         = r_done_p1;
    assign bus.sof          = r_sof_p1;
    assign bus.output_valid = r_vld_p1;
    assign bus.d_out        = r_dout_p1;
endmodule

// File: doc/frame_stream_source.md
# frame_stream_source

Frame-stream transmitter for the CNN pipeline: holds one input_x × input_y feature map of 32-bit words in an internal RAM loaded through a simple write port. On a start pulse it replays the map in raster order as the sof / data / valid stream consumed by the pooling and line-buffer layers. It is the driving end of that interface and is used by layer-level testbenches and by the top level to feed the first layer from a preloaded frame.

## Interface
- data_width, 32, word width of stored and streamed data
- input_x, 5, number of rows per frame
- input_y, 5, words per row (line length seen by the downstream line buffer)
- row_gap, 0, idle cycles inserted after each row except the last (0..255)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- wr_en  in  1  write strobe for frame RAM
- wr_addr  in  clog2(input_x*input_y)  raster address, row*input_y + col
- wr_data  in  data_width  word to store
- start  in  1  one-cycle request to stream the stored frame
- busy  out  1  frame transmission in progress
- done  out  1  one-cycle pulse after the last word is sent
- sof  out  1  start of frame, asserted only with the first word
- output_valid  out  1  d_out carries a valid word this cycle
- d_out  out  data_width  streamed word

## Operation
- Frame RAM: input_x*input_y words, synchronous read with 1-cycle latency, not cleared by reset; contents persist across frames and resets.
- Writes: accepted when wr_en=1, busy=0 and wr_addr < input_x*input_y; all other writes are dropped silently.
- FSM states: IDLE, STREAM, GAP, FLUSH.
  - IDLE: start=1 → STREAM with row=0, col=0; busy rises the next cycle.
  - STREAM: one RAM read per cycle at row*input_y+col, col increments. On col=input_y-1: if last row → FLUSH; else if row_gap>0 → GAP (load gap counter = row_gap); else stay in STREAM with col=0, row+1.
  - GAP: counts down row_gap cycles, no reads, then STREAM with col=0, row+1.
  - FLUSH: waits one cycle for the final RAM read to emerge, then → IDLE and asserts done.
- output_valid and sof are the read-issue flags delayed one cycle, aligned with RAM output. sof=1 only for address 0 of each frame.
- d_out holds its last value when output_valid=0.
- start while busy=1 is ignored. A start in the same cycle as done is also ignored; the next start is accepted once done has been seen.
- Counters use exact widths: col up to input_y-1, row up to input_x-1, and gap of 8 bits.

## Timing
- Reset (rst=0 at a rising edge): state=IDLE; busy, done, sof, output_valid and d_out are all 0 the following cycle. This applies mid-frame too: the stream aborts with no done pulse.
- Let start be sampled at edge k. Then busy=1 from edge k+1. The first word, with sof=1 and output_valid=1, appears after edge k+2.
- Words within a row are on consecutive cycles. After each non-final row, output_valid=0 for exactly row_gap cycles.
- Frame duration from first valid to last valid: input_x*input_y + (input_x-1)*row_gap cycles.
- done=1 for one cycle, in the cycle immediately after the last valid word. busy falls in the same cycle that done is asserted.
- output_valid never asserts when busy was 0 in the previous cycle.

## Test plan
- Reset values: hold rst=0 for 3 cycles while start=1 and wr_en=1 → all outputs 0, no writes stored (the RAM read-back later shows the old contents).
- Basic frame: input_x=3, input_y=4, row_gap=0; write 100+i to addresses 0..11; pulse start → 12 consecutive valid words 100..111; sof only with 100; first valid 2 cycles after start; done one cycle after 111.
- Row gap: same frame with row_gap=2 → gaps of 2 idle cycles after 103 and after 107; 16 cycles from the first valid word to the last; no gap after 111.
- Protocol abuse: start re-pulsed mid-frame, wr_en to address 5 with value 999 while busy, and wr_addr=12 while idle → the stream is unchanged, and a second frame still outputs 105 at address 5 with no out-of-range corruption.
- Reset mid-frame: assert rst=0 after the 6th valid word → outputs 0 next cycle with no done; a new start then replays the full frame from 100 with sof.
- Back-to-back: pulse start in the cycle after done → the second frame is identical to the first, with exactly one sof per frame.
